ifetch_ctrl: RTL
================

Name: ifetch_ctrl

Overview:
- Instruction fetch controller for the 16-bit CPU. Owns the program counter and sequences a synchronous, byte-wide, single-port instruction memory: two byte reads per instruction, big-endian {byte[PC], byte[PC+1]}.
- Presents each instruction to decode over a valid/ready handshake.
- Handles branch redirect and halt.
- Arbitrates the memory port between fetch and a program loader that writes bytes while the CPU is idle.

Parameters:
- ADDR_W, 7, byte-address width of the instruction memory (depth 2^ADDR_W = 128 bytes).
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-low reset.
- Start  input  1  begin fetching from the current PC (honoured only in IDLE).
- Halt  input  1  stop fetching; discard the in-flight instruction.
- BranchTaken  input  1  redirect request.
- BranchTarget  input  16  redirect PC.
- InstrReady  input  1  decode accepts the instruction.
- InstrValid  output  1  Instruction/InstrPC valid.
- Instruction  output  16  fetched instruction.
- InstrPC  output  16  address of Instruction.
- PC  output  16  current fetch PC.
- Running  output  1  high when state is not IDLE.
- MemAddr  output  ADDR_W  memory byte address.
- MemRdData  input  8  read data; valid one cycle after MemAddr.
- MemWrData  output  8  write data.
- MemWrEn  output  1  memory write strobe.
- LoadEn  input  1  loader write request.
- LoadAddr  input  ADDR_W  loader byte address.
- LoadData  input  8  loader byte.
- LoadGnt  output  1  loader write performed this cycle.
- Fault  output  1  sticky fetch fault.

Behaviour:
- Reset (Reset==0 at an edge) forces the following, and also aborts any operation in progress:
  - state=IDLE, PC=RESET_PC
  - InstrValid=0, Instruction=0, InstrPC=0, Fault=0
  - LoadGnt=0 and MemWrEn=0 while Reset is low.
- States: IDLE, RD_HI, RD_LO, CAP, VALID.
- IDLE:
  - MemAddr=LoadAddr when LoadGnt, else 0.
  - LoadGnt = LoadEn & Reset.
  - MemWrEn=LoadGnt, MemWrData=LoadData.
  - Start & !LoadEn -> RD_HI and clears Fault. Start with LoadEn high is ignored.
- RD_HI: MemAddr=PC[ADDR_W-1:0] -> RD_LO.
- RD_LO: MemAddr=(PC+1)[ADDR_W-1:0] (wraps modulo depth); register hi byte from MemRdData -> CAP.
- CAP: register lo byte; Instruction={hi,lo}; InstrPC=PC -> VALID.
- VALID:
  - InstrValid=1; Instruction and InstrPC held stable until handshake.
  - InstrValid & InstrReady -> PC=PC+2 (16-bit wrap), InstrValid=0 next cycle, then RD_HI.
- Fetch latency: 3 cycles from entering RD_HI to InstrValid=1. Sustained rate: one instruction per 4 cycles with InstrReady tied high.
- Priority each cycle, when not IDLE: LoadEn > Halt > BranchTaken > handshake.
  - LoadEn while running acts as Halt; the loader is granted from the next cycle (in IDLE).
  - Halt -> IDLE next cycle; InstrValid=0; in-flight bytes discarded; PC unchanged, so it points at the unaccepted instruction.
  - BranchTaken -> PC=BranchTarget; InstrValid=0; in-flight data discarded; next state RD_HI.
  - BranchTaken in the same cycle as a handshake: the instruction counts as consumed, and PC=BranchTarget (not PC+2).
- BranchTaken, Halt and InstrReady are ignored in IDLE.
- MemWrEn is never asserted outside IDLE. MemAddr=0 in CAP and VALID.
- No read is issued in a cycle where a loader write occurs.

Optional Feature:
- Macro IFETCH_FAULT_EN.
- Defined: on entry to RD_HI (via Start, handshake, or branch), if PC[0]==1 or PC >= 2^ADDR_W (PC+1 also in range), the controller:
  - sets Fault=1 (sticky)
  - goes to IDLE instead of RD_HI, issuing no read
  - leaves PC holding the offending value.
  - Fault is cleared only by Reset or an accepted Start.
- Undefined: Fault tied 0; all addresses are silently truncated to ADDR_W bits.

Test Plan:
- Memory bytes 0x12,0x34,0xAB,0xCD at addresses 0..3; reset; Start; InstrReady=1 -> InstrValid 3 cycles after RD_HI, Instruction=0x1234 with InstrPC=0; then 0xABCD with InstrPC=2, 4 cycles later; PC=4.
- InstrReady held low 5 cycles in VALID -> Instruction stays 0x1234 and InstrValid stays 1; PC stays 0 until the handshake.
- BranchTaken with BranchTarget=0x0040 during RD_LO -> no InstrValid for the discarded fetch; next MemAddr=0x40, 0x41; InstrPC=0x0040.
- Halt in CAP -> IDLE, InstrValid=0, PC unchanged. Then LoadEn with LoadAddr=0x10, LoadData=0x5A -> LoadGnt=MemWrEn=1 the same cycle; read back via BranchTarget later shows 0x5A in the hi byte.
- Reset low for one cycle while in VALID -> next cycle InstrValid=0, PC=RESET_PC, Running=0, Fault=0.
- IFETCH_FAULT_EN defined: branch to 0x0003 -> Fault=1, state IDLE, no MemAddr read; Start with PC=0x0003 still misaligned re-faults. Undefined: PC=0x007E then PC+1 reads address 0x7F, and the next fetch from PC=0x0080 reads addresses 0x00, 0x01.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: owns the PC, reads big-endian 16-bit instructions from a
// byte-wide sync memory and shares the port with an idle-time loader. Option: IFETCH_FAULT_EN.
module ifetch_ctrl #(
  parameter int unsigned ADDR_W   = 7,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic              branch_taken,
  input  logic [15:0]       branch_target,
  input  logic              instr_ready,
  output logic              instr_valid,
  output logic [15:0]       instruction,
  output logic [15:0]       instr_pc,
  output logic [15:0]       pc,
  output logic              running,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        mem_wr_data,
  output logic              mem_wr_en,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_gnt,
  output logic              fault
);

  typedef enum logic [2:0] {StIdle, StRdHi, StRdLo, StCap, StValid} state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [7:0]  hi_q;
  logic [15:0] instr_q;
  logic [15:0] instr_pc_q;
  logic        valid_q;
  logic        fault_q;

  logic [ADDR_W-1:0] pc_lo;
  logic [15:0]       fetch_pc;
  logic              bad_fetch;
  logic              handshake;

  assign pc_lo     = pc_q[ADDR_W-1:0];
  assign handshake = (state_q == StValid) && valid_q && instr_ready;

  // PC that the next RD_HI entry would fetch from: Start reuses PC, branch wins over handshake.
  always_comb begin
    fetch_pc = pc_q;
    if (state_q != StIdle) begin
      fetch_pc = branch_taken ? branch_target : pc_q + 16'd2;
    end
  end

`ifdef IFETCH_FAULT_EN
  assign bad_fetch = fetch_pc[0] || (fetch_pc >= 16'(2 ** ADDR_W));
`else
  assign bad_fetch = 1'b0;
`endif

  assign load_gnt    = (state_q == StIdle) && load_en && reset;
  assign mem_wr_en   = load_gnt;
  assign mem_wr_data = load_data;

  always_comb begin
    mem_addr = '0;
    unique case (state_q)
      StIdle:  if (load_gnt) mem_addr = load_addr;
      StRdHi:  mem_addr = pc_lo;
      StRdLo:  mem_addr = pc_lo + ADDR_W'(1);
      default: mem_addr = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      hi_q       <= 8'h00;
      instr_q    <= 16'h0000;
      instr_pc_q <= 16'h0000;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !load_en) begin
            pc_q    <= fetch_pc;
            fault_q <= bad_fetch;
            state_q <= bad_fetch ? StIdle : StRdHi;
          end
        end
        default: begin
          if (load_en || halt) begin
            // PC is left pointing at the instruction that was not accepted.
            state_q <= StIdle;
            valid_q <= 1'b0;
          end else if (branch_taken || handshake) begin
            pc_q    <= fetch_pc;
            valid_q <= 1'b0;
            if (bad_fetch) fault_q <= 1'b1;
            state_q <= bad_fetch ? StIdle : StRdHi;
          end else begin
            case (state_q)
              StRdHi: state_q <= StRdLo;
              StRdLo: begin
                hi_q    <= mem_rd_data;
                state_q <= StCap;
              end
              StCap: begin
                instr_q    <= {hi_q, mem_rd_data};
                instr_pc_q <= pc_q;
                valid_q    <= 1'b1;
                state_q    <= StValid;
              end
              default: state_q <= state_q;
            endcase
          end
        end
      endcase
    end
  end

  assign instr_valid = valid_q;
  assign instruction = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc          = pc_q;
  assign running     = (state_q != StIdle);
  assign fault       = fault_q;

endmodule
